// File: rtl/bus_master_if.sv
// Single-master bus interface: CPU access strobe -> arbiter request/grant -> one bus access.
// Optional ACCESS timeout with err pulse is enabled by defining BUS_MASTER_TIMEOUT_EN.
module bus_master_if #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        as_,
    input  logic        rw,
    input  logic [29:0] addr,
    input  logic [31:0] wr_data,
    input  logic        stall,
    output logic [31:0] rd_data,
    output logic        busy,
    output logic        err,
    output logic        bus_req_,
    input  logic        bus_grnt_,
    output logic        bus_as_,
    output logic        bus_rw,
    output logic [29:0] bus_addr,
    output logic [31:0] bus_wr_data,
    input  logic [31:0] bus_rd_data,
    input  logic        bus_rdy_
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        ACCESS = 2'd2,
        STALL  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        bus_req_n_q, bus_req_n_d;
    logic        bus_as_n_q, bus_as_n_d;
    logic        bus_rw_q, bus_rw_d;
    logic [29:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wr_data_q, bus_wr_data_d;
    logic [31:0] rd_data_q, rd_data_d;

`ifdef BUS_MASTER_TIMEOUT_EN
    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYC);
    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;
`else
    logic [7:0] unused_timeout_cyc;
    assign unused_timeout_cyc = 8'(TIMEOUT_CYC);
`endif

    always_comb begin
        state_d       = state_q;
        bus_req_n_d   = bus_req_n_q;
        bus_as_n_d    = bus_as_n_q;
        bus_rw_d      = bus_rw_q;
        bus_addr_d    = bus_addr_q;
        bus_wr_data_d = bus_wr_data_q;
        rd_data_d     = rd_data_q;
`ifdef BUS_MASTER_TIMEOUT_EN
        cnt_d         = cnt_q;
        err_d         = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                bus_req_n_d = 1'b1;
                bus_as_n_d  = 1'b1;
                if (!as_) begin
                    bus_addr_d    = addr;
                    bus_rw_d      = rw;
                    bus_wr_data_d = wr_data;
                    bus_req_n_d   = 1'b0;
                    state_d       = REQ;
                end
            end
            REQ: begin
                if (!bus_grnt_) begin
                    bus_as_n_d = 1'b0;
                    state_d    = ACCESS;
`ifdef BUS_MASTER_TIMEOUT_EN
                    cnt_d      = 8'd0;
`endif
                end
            end
            ACCESS: begin
                // Strobe lasts only the first ACCESS cycle; request is held until completion.
                bus_as_n_d = 1'b1;
                if (!bus_rdy_) begin
                    if (bus_rw_q) begin
                        rd_data_d = bus_rd_data;
                    end
                    bus_req_n_d = 1'b1;
                    state_d     = stall ? STALL : IDLE;
                end
`ifdef BUS_MASTER_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == LIMIT) begin
                        err_d       = 1'b1;
                        bus_req_n_d = 1'b1;
                        if (bus_rw_q) begin
                            rd_data_d = 32'd0;
                        end
                        state_d = stall ? STALL : IDLE;
                    end
                end
`endif
            end
            STALL: begin
                if (!stall) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            bus_req_n_q   <= 1'b1;
            bus_as_n_q    <= 1'b1;
            bus_rw_q      <= 1'b1;
            bus_addr_q    <= 30'd0;
            bus_wr_data_q <= 32'd0;
            rd_data_q     <= 32'd0;
`ifdef BUS_MASTER_TIMEOUT_EN
            cnt_q         <= 8'd0;
            err_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            bus_req_n_q   <= bus_req_n_d;
            bus_as_n_q    <= bus_as_n_d;
            bus_rw_q      <= bus_rw_d;
            bus_addr_q    <= bus_addr_d;
            bus_wr_data_q <= bus_wr_data_d;
            rd_data_q     <= rd_data_d;
`ifdef BUS_MASTER_TIMEOUT_EN
            cnt_q         <= cnt_d;
            err_q         <= err_d;
`endif
        end
    end

    // CPU may present a new strobe in IDLE; busy reflects it so the CPU holds immediately.
    assign busy = (state_q == IDLE) ? ~as_ : (state_q != STALL);

    assign bus_req_    = bus_req_n_q;
    assign bus_as_     = bus_as_n_q;
    assign bus_rw      = bus_rw_q;
    assign bus_addr    = bus_addr_q;
    assign bus_wr_data = bus_wr_data_q;
    assign rd_data     = rd_data_q;

`ifdef BUS_MASTER_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_master_if.sv
// Randomized transaction bench for bus_master_if against a transaction-level reference model.
module tb_bus_master_if;
    localparam int TC = 4;
`ifdef BUS_MASTER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        as_, rw, stall;
    logic [29:0] addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        busy, err;
    logic        bus_req_, bus_grnt_, bus_as_, bus_rw;
    logic [29:0] bus_addr;
    logic [31:0] bus_wr_data, bus_rd_data;
    logic        bus_rdy_;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_rd  = 32'd0;

    always #5 clk = ~clk;

    bus_master_if #(.TIMEOUT_CYC(TC)) dut (
        .clk(clk), .reset(reset), .as_(as_), .rw(rw), .addr(addr), .wr_data(wr_data),
        .stall(stall), .rd_data(rd_data), .busy(busy), .err(err), .bus_req_(bus_req_),
        .bus_grnt_(bus_grnt_), .bus_as_(bus_as_), .bus_rw(bus_rw), .bus_addr(bus_addr),
        .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // g: REQ cycles before grant, r: ACCESS cycles before ready, s: cycles spent in STALL.
    task automatic do_txn(input logic t_rw, input logic [29:0] t_addr, input logic [31:0] t_wd,
                          input logic [31:0] t_rd, input int g, input int r, input int s);
        bit to;
        int n_acc;
        to    = TO_EN && (r >= TC);
        n_acc = to ? TC : r + 1;

        as_ = 1'b0; rw = t_rw; addr = t_addr; wr_data = t_wd; stall = (s > 0);
        bus_grnt_ = 1'($urandom); bus_rdy_ = 1'($urandom);
        #1;
        chk("idle_busy", 32'(busy), 32'd1);
        chk("idle_req", 32'(bus_req_), 32'd1);
        tick();

        as_ = 1'b1; rw = 1'($urandom); addr = 30'($urandom); wr_data = $urandom;
        for (int k = 0; k <= g; k++) begin
            bus_grnt_ = (k == g) ? 1'b0 : 1'b1;
            bus_rdy_  = 1'($urandom);
            #1;
            chk("req_req", 32'(bus_req_), 32'd0);
            chk("req_as", 32'(bus_as_), 32'd1);
            chk("req_busy", 32'(busy), 32'd1);
            chk("req_addr", 32'(bus_addr), 32'(t_addr));
            chk("req_wd", bus_wr_data, t_wd);
            chk("req_rw", 32'(bus_rw), 32'(t_rw));
            tick();
        end

        for (int j = 0; j < n_acc; j++) begin
            bus_grnt_   = 1'($urandom);
            bus_rdy_    = (j == r) ? 1'b0 : 1'b1;
            bus_rd_data = (j == r) ? t_rd : $urandom;
            #1;
            chk("acc_as", 32'(bus_as_), (j == 0) ? 32'd0 : 32'd1);
            chk("acc_req", 32'(bus_req_), 32'd0);
            chk("acc_busy", 32'(busy), 32'd1);
            chk("acc_err", 32'(err), 32'd0);
            chk("acc_addr", 32'(bus_addr), 32'(t_addr));
            chk("acc_wd", bus_wr_data, t_wd);
            chk("acc_rd_hold", rd_data, exp_rd);
            tick();
        end

        if (t_rw) exp_rd = to ? 32'd0 : t_rd;
        chk("done_err", 32'(err), 32'(to));
        chk("done_rd", rd_data, exp_rd);
        chk("done_req", 32'(bus_req_), 32'd1);
        chk("done_as", 32'(bus_as_), 32'd1);

        for (int k = 0; k < s; k++) begin
            as_         = 1'($urandom);
            stall       = (k == s - 1) ? 1'b0 : 1'b1;
            bus_rdy_    = 1'($urandom);
            bus_rd_data = $urandom;
            #1;
            chk("stall_busy", 32'(busy), 32'd0);
            chk("stall_req", 32'(bus_req_), 32'd1);
            chk("stall_rd", rd_data, exp_rd);
            tick();
        end

        as_ = 1'b1; stall = 1'b0;
        #1;
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_req", 32'(bus_req_), 32'd1);
        chk("end_as", 32'(bus_as_), 32'd1);
        chk("end_err", 32'(err), 32'd0);
        chk("end_rd", rd_data, exp_rd);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"}, 32'(bus_req_), 32'd1);
        chk({tag, "_as"}, 32'(bus_as_), 32'd1);
        chk({tag, "_rw"}, 32'(bus_rw), 32'd1);
        chk({tag, "_addr"}, 32'(bus_addr), 32'd0);
        chk({tag, "_wd"}, bus_wr_data, 32'd0);
        chk({tag, "_rd"}, rd_data, 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        reset = 1'b1; as_ = 1'b1; rw = 1'b0; addr = '0; wr_data = '0; stall = 1'b0;
        bus_grnt_ = 1'b1; bus_rdy_ = 1'b1; bus_rd_data = '0;
        #3;
        chk_reset_vals("rst");
        @(negedge clk);
        reset = 1'b0;
        tick();

        do_txn(1'b1, 30'($urandom), $urandom, 32'hDEADBEEF, 0, 0, 0);
        do_txn(1'b0, 30'h0000_0100, 32'h1234_5678, $urandom, 4, 2, 0);
        do_txn(1'b1, 30'($urandom), $urandom, $urandom, 0, 1, 3);
        do_txn(1'b1, 30'($urandom), $urandom, $urandom, 0, TC, 0);
        do_txn(1'b1, 30'($urandom), $urandom, $urandom, 1, TC - 1, 0);
        do_txn(1'b0, 30'($urandom), $urandom, $urandom, 0, TC + 1, 2);

        for (int i = 0; i < 40; i++) begin
            do_txn(1'($urandom), 30'($urandom), $urandom, $urandom,
                   int'($urandom_range(0, 4)), int'($urandom_range(0, 6)),
                   int'($urandom_range(0, 3)));
        end

        // Abandon a read two cycles into ACCESS.
        as_ = 1'b0; rw = 1'b1; addr = 30'h3ABC_1234; wr_data = 32'hCAFE_F00D; bus_grnt_ = 1'b0;
        tick();
        as_ = 1'b1; bus_rdy_ = 1'b1;
        tick();
        tick();
        tick();
        #2 reset = 1'b1;
        #1;
        exp_rd = 32'd0;
        chk_reset_vals("midrst");
        @(negedge clk);
        reset = 1'b0;
        tick();
        do_txn(1'b1, 30'($urandom), $urandom, 32'h5A5A_A5A5, 0, 0, 0);
        do_txn(1'b0, 30'($urandom), $urandom, $urandom, 2, 1, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
